jelly_rasterizer_edge_setup: RTL and testbench
==============================================

// Module: jelly_rasterizer_edge_setup
// PURPOSE
//  Triangle edge-setup engine: accepts three screen-space vertices and computes, per edge, the dx / dy_stride /
//  offset coefficients consumed by jelly_rasterizer_plane_calc (edge function region test). Sits between the
//  vertex front-end and the raster scan; one shared multiplier, sequenced by an FSM, valid/ready on both sides.
// PARAMETERS
//  X_NUM        640  scan width in pixels; used for dy_stride = dy - (X_NUM-1)*dx
//  COORD_WIDTH  12   signed vertex coordinate width
//  REGION_WIDTH 20   signed width of each output coefficient
// PORTS
//  reset        in   1                 synchronous, active-high
//  clk          in   1                 clock
//  cke          in   1                 clock enable; 0 freezes all state and outputs
//  s_x          in   3*COORD_WIDTH     vertex x, vertex i at [i*COORD_WIDTH +: COORD_WIDTH], signed
//  s_y          in   3*COORD_WIDTH     vertex y, same packing
//  s_valid      in   1                 vertex set valid
//  s_ready      out  1                 engine idle, can accept
//  m_dx         out  3*REGION_WIDTH    edge j dx at [j*REGION_WIDTH +: REGION_WIDTH]
//  m_dy_stride  out  3*REGION_WIDTH    edge j dy_stride, same packing
//  m_offset     out  3*REGION_WIDTH    edge j offset, same packing
//  m_overflow   out  1                 some coefficient did not fit REGION_WIDTH signed
//  m_valid      out  1                 coefficient set valid
//  m_ready      in   1                 downstream accepts
// BEHAVIOUR
//  Math, edge j=0..2, k=(j+1)%3, full precision (2*COORD_WIDTH+12 bits signed internal):
//   dx=y[k]-y[j]; ex=x[k]-x[j]; offset=y[j]*ex - x[j]*dx; dy=-ex; dy_stride=dy-(X_NUM-1)*dx.
//   Outputs = low REGION_WIDTH bits (two's-complement truncation). m_overflow = OR over all 9 values of
//   (value outside [-2^(REGION_WIDTH-1), 2^(REGION_WIDTH-1)-1]); results still delivered.
//  Reset: state IDLE, s_ready=0 during reset then 1, m_valid=0, m_dx/m_dy_stride/m_offset=0, m_overflow=0.
//  FSM (advances only when cke=1):
//   IDLE : s_ready=1. s_valid&&s_ready -> latch s_x/s_y, edge=0, clear overflow acc -> DIFF.
//   DIFF : register dx, ex for current edge -> MUL_A.
//   MUL_A: acc = y[j]*ex -> MUL_B.
//   MUL_B: offset = acc - x[j]*dx; store offset[j] -> MUL_C.
//   MUL_C: store dx[j], dy_stride[j]; edge<2 -> edge+1, DIFF; edge==2 -> OUT.
//   OUT  : m_valid=1, outputs stable; m_valid&&m_ready -> IDLE (m_valid=0 next cycle).
//  Latency: m_valid rises exactly 12 enabled clocks after the accepting edge. One multiply per cycle.
//  s_ready=0 in all states except IDLE; no accept in the OUT->IDLE cycle (min 14 cycles per triangle).
//  Inputs s_x/s_y ignored after acceptance (internally latched); may change freely.
//  Backpressure: m_ready=0 holds OUT indefinitely with all outputs unchanged.
//  Output registers update only at OUT entry; they keep last result while IDLE (m_valid=0).
//  Reset mid-operation: abort immediately, IDLE, m_valid=0, outputs cleared.
//  cke=0 in any state: no transition, no handshake completes (s_valid/m_ready ignored).
//  Degenerate triangle (collinear/coincident vertices): no special case; coefficients computed as per math.
// TESTING
//  1 V=(123,111),(512,91),(300,390), X_NUM=640 -> dx={-20,299,-279}, dy_stride={12391,-190849,178458},
//    offset={45639,-172380,14670}, m_overflow=0, m_valid 12 cycles after accept.
//  2 Same input, m_ready=0 for 20 cycles after m_valid -> outputs/m_valid stable, s_ready=0 throughout;
//    m_ready=1 -> m_valid=0 and s_ready=1 next cycle.
//  3 V=(0,-2048),(0,2047),(0,0) -> edge0 dx=4095, dy_stride=-2616705 (out of 20b) -> m_overflow=1.
//  4 Back-to-back triangles, s_valid held high, m_ready=1 -> second accept 14 cycles after first, both correct.
//  5 reset pulsed at cycle 6 of processing -> m_valid stays 0, outputs 0; next triangle then correct.
//  6 cke toggled 0/1 every other cycle during test 1 -> identical results, m_valid after 12 enabled clocks.

Source files
------------

// File: rtl/jelly_rasterizer_edge_setup.sv
// jelly_rasterizer_edge_setup
//   Triangle edge-setup engine. Latches three screen-space vertices and, using a
//   single shared multiplier sequenced by an FSM, computes per edge j (k=(j+1)%3):
//     dx        = y[k]-y[j]
//     dy_stride = -(x[k]-x[j]) - (X_NUM-1)*dx
//     offset    = y[j]*(x[k]-x[j]) - x[j]*dx
//   Results are truncated to REGION_WIDTH; m_overflow flags any value that did not fit.
// Ports
//   reset, clk, cke        : synchronous active-high reset, clock, clock enable
//   s_x, s_y, s_valid      : packed vertex set (vertex i at [i*COORD_WIDTH +: COORD_WIDTH])
//   s_ready                : engine idle, vertex set can be accepted
//   m_dx, m_dy_stride,
//   m_offset               : packed coefficients (edge j at [j*REGION_WIDTH +: REGION_WIDTH])
//   m_overflow             : some coefficient outside REGION_WIDTH signed range
//   m_valid, m_ready       : output handshake
module jelly_rasterizer_edge_setup #(
   parameter int unsigned X_NUM        = 640,
   parameter int unsigned COORD_WIDTH  = 12,
   parameter int unsigned REGION_WIDTH = 20
) (
   input  logic                        reset,
   input  logic                        clk,
   input  logic                        cke,
   input  logic [3*COORD_WIDTH-1:0]    s_x,
   input  logic [3*COORD_WIDTH-1:0]    s_y,
   input  logic                        s_valid,
   output logic                        s_ready,
   output logic [3*REGION_WIDTH-1:0]   m_dx,
   output logic [3*REGION_WIDTH-1:0]   m_dy_stride,
   output logic [3*REGION_WIDTH-1:0]   m_offset,
   output logic                        m_overflow,
   output logic                        m_valid,
   input  logic                        m_ready
);

   localparam int unsigned CW = COORD_WIDTH;
   localparam int unsigned RW = REGION_WIDTH;
   localparam int unsigned FW = 2*COORD_WIDTH + 12;
   localparam logic signed [FW-1:0] XM1 = FW'(X_NUM - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_DIFF, ST_MUL_A, ST_MUL_B, ST_MUL_C, ST_OUT
   } state_t;

   state_t state_q, state_d;

   logic [3*CW-1:0]       x_q, x_d, y_q, y_d;
   logic [1:0]            edge_q, edge_d;
   logic signed [FW-1:0]  dx_q, dx_d, ex_q, ex_d, acc_q, acc_d;
   logic                  ovf_q, ovf_d;
   logic [3*RW-1:0]       dx_all_q, dx_all_d, dys_all_q, dys_all_d, off_all_q, off_all_d;
   logic [3*RW-1:0]       m_dx_q, m_dx_d, m_dys_q, m_dys_d, m_off_q, m_off_d;
   logic                  m_ovf_q, m_ovf_d, m_valid_q, m_valid_d, s_ready_q, s_ready_d;

   logic signed [CW-1:0]  xj, yj, xk, yk;
   logic signed [FW-1:0]  mul_a, mul_b, prod, off_v, dys_v;

   // true when v does not fit in RW-bit two's complement
   function automatic logic out_of_range(input logic signed [FW-1:0] v);
      out_of_range = (v[FW-1:RW-1] != '0) && (v[FW-1:RW-1] != '1);
   endfunction

   // state register
   always_ff @(posedge clk) begin
      if (reset)    state_q <= ST_IDLE;
      else if (cke) state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (s_valid && s_ready_q) state_d = ST_DIFF;
         ST_DIFF:  state_d = ST_MUL_A;
         ST_MUL_A: state_d = ST_MUL_B;
         ST_MUL_B: state_d = ST_MUL_C;
         ST_MUL_C: state_d = (edge_q == 2'd2) ? ST_OUT : ST_DIFF;
         ST_OUT:   if (m_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // vertex j / k selection for the current edge
   always_comb begin
      case (edge_q)
         2'd0: begin
            xj = x_q[0 +: CW];    yj = y_q[0 +: CW];
            xk = x_q[CW +: CW];   yk = y_q[CW +: CW];
         end
         2'd1: begin
            xj = x_q[CW +: CW];   yj = y_q[CW +: CW];
            xk = x_q[2*CW +: CW]; yk = y_q[2*CW +: CW];
         end
         default: begin
            xj = x_q[2*CW +: CW]; yj = y_q[2*CW +: CW];
            xk = x_q[0 +: CW];    yk = y_q[0 +: CW];
         end
      endcase
   end

   // shared multiplier operand mux: one product per cycle
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state_q)
         ST_MUL_A: begin mul_a = FW'(yj); mul_b = ex_q; end
         ST_MUL_B: begin mul_a = FW'(xj); mul_b = dx_q; end
         ST_MUL_C: begin mul_a = XM1;     mul_b = dx_q; end
         default:  ;
      endcase
      prod = mul_a * mul_b;
   end

   // output / datapath next values
   always_comb begin
      x_d       = x_q;
      y_d       = y_q;
      edge_d    = edge_q;
      dx_d      = dx_q;
      ex_d      = ex_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      dx_all_d  = dx_all_q;
      dys_all_d = dys_all_q;
      off_all_d = off_all_q;
      m_dx_d    = m_dx_q;
      m_dys_d   = m_dys_q;
      m_off_d   = m_off_q;
      m_ovf_d   = m_ovf_q;
      off_v     = acc_q - prod;
      dys_v     = -ex_q - prod;
      m_valid_d = (state_d == ST_OUT);
      s_ready_d = (state_d == ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (s_valid && s_ready_q) begin
               x_d    = s_x;
               y_d    = s_y;
               edge_d = 2'd0;
               ovf_d  = 1'b0;
            end
         end
         ST_DIFF: begin
            dx_d = FW'(yk) - FW'(yj);
            ex_d = FW'(xk) - FW'(xj);
         end
         ST_MUL_A: acc_d = prod;
         ST_MUL_B: begin
            off_all_d[edge_q*RW +: RW] = off_v[RW-1:0];
            ovf_d = ovf_q | out_of_range(off_v);
         end
         ST_MUL_C: begin
            dx_all_d[edge_q*RW +: RW]  = dx_q[RW-1:0];
            dys_all_d[edge_q*RW +: RW] = dys_v[RW-1:0];
            ovf_d = ovf_q | out_of_range(dx_q) | out_of_range(dys_v);
            if (edge_q == 2'd2) begin
               // last edge: publish the whole set on OUT entry
               m_dx_d  = dx_all_d;
               m_dys_d = dys_all_d;
               m_off_d = off_all_d;
               m_ovf_d = ovf_d;
            end else begin
               edge_d = edge_q + 2'd1;
            end
         end
         default: ;
      endcase
   end

   // datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         x_q       <= '0;
         y_q       <= '0;
         edge_q    <= '0;
         dx_q      <= '0;
         ex_q      <= '0;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         dx_all_q  <= '0;
         dys_all_q <= '0;
         off_all_q <= '0;
         m_dx_q    <= '0;
         m_dys_q   <= '0;
         m_off_q   <= '0;
         m_ovf_q   <= 1'b0;
         m_valid_q <= 1'b0;
         s_ready_q <= 1'b0;
      end else if (cke) begin
         x_q       <= x_d;
         y_q       <= y_d;
         edge_q    <= edge_d;
         dx_q      <= dx_d;
         ex_q      <= ex_d;
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
         dx_all_q  <= dx_all_d;
         dys_all_q <= dys_all_d;
         off_all_q <= off_all_d;
         m_dx_q    <= m_dx_d;
         m_dys_q   <= m_dys_d;
         m_off_q   <= m_off_d;
         m_ovf_q   <= m_ovf_d;
         m_valid_q <= m_valid_d;
         s_ready_q <= s_ready_d;
      end
   end

   assign s_ready     = s_ready_q;
   assign m_dx        = m_dx_q;
   assign m_dy_stride = m_dys_q;
   assign m_offset    = m_off_q;
   assign m_overflow  = m_ovf_q;
   assign m_valid     = m_valid_q;

endmodule

// File: tb/tb_jelly_rasterizer_edge_setup.sv
// Directed bench for jelly_rasterizer_edge_setup: hand-computed coefficient sets,
// latency, backpressure, back-to-back, mid-operation reset and clock-enable gating.
module tb_jelly_rasterizer_edge_setup;

   localparam int CW = 12;
   localparam int RW = 20;

   logic              clk = 1'b0;
   logic              reset, cke;
   logic [3*CW-1:0]   s_x, s_y;
   logic              s_valid, s_ready;
   logic [3*RW-1:0]   m_dx, m_dy_stride, m_offset;
   logic              m_overflow, m_valid, m_ready;

   int n_checks = 0;
   int n_errors = 0;

   int T1_DX[3]  = '{-20, 299, -279};
   int T1_DYS[3] = '{12391, -190849, 178458};
   int T1_OFF[3] = '{45639, -172380, 14670};
   int T3_DX[3]  = '{4095, -2047, -2048};
   int T3_DYS[3] = '{-2616705, 1308033, 1308672};
   int T3_OFF[3] = '{0, 0, 0};

   logic [3*CW-1:0] v1x, v1y, v3x, v3y;

   jelly_rasterizer_edge_setup #(
      .X_NUM(640), .COORD_WIDTH(CW), .REGION_WIDTH(RW)
   ) dut (
      .reset(reset), .clk(clk), .cke(cke),
      .s_x(s_x), .s_y(s_y), .s_valid(s_valid), .s_ready(s_ready),
      .m_dx(m_dx), .m_dy_stride(m_dy_stride), .m_offset(m_offset),
      .m_overflow(m_overflow), .m_valid(m_valid), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [3*CW-1:0] pk(input int a, input int b, input int c);
      logic [31:0] ua, ub, uc;
      ua = a; ub = b; uc = c;
      pk = {uc[CW-1:0], ub[CW-1:0], ua[CW-1:0]};
   endfunction

   function automatic logic [31:0] lo20(input int v);
      logic [31:0] u;
      u = v;
      lo20 = {12'd0, u[RW-1:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input int edx[3], input int edys[3],
                            input int eoff[3], input logic eovf);
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("%s dx%0d", tag, j),  {12'd0, m_dx[j*RW +: RW]},        lo20(edx[j]));
         chk($sformatf("%s dys%0d", tag, j), {12'd0, m_dy_stride[j*RW +: RW]}, lo20(edys[j]));
         chk($sformatf("%s off%0d", tag, j), {12'd0, m_offset[j*RW +: RW]},    lo20(eoff[j]));
      end
      chk({tag, " ovf"}, 32'(m_overflow), 32'(eovf));
   endtask

   // accept one vertex set and wait for m_valid (m_ready held low)
   task automatic run_tri(input string tag, input logic [3*CW-1:0] vx,
                          input logic [3*CW-1:0] vy, input bit tog);
      int w, lat, guard;
      logic c;
      cke = 1'b1; m_ready = 1'b0;
      s_x = vx; s_y = vy; s_valid = 1'b1;
      w = 0;
      while (!s_ready && w < 50) begin tick(); w++; end
      chk({tag, " ready"}, 32'(s_ready), 32'd1);
      tick();
      s_valid = 1'b0;
      s_x = 36'($urandom); s_y = 36'($urandom);
      chk({tag, " busy"}, 32'(s_ready), 32'd0);
      lat = 0; guard = 0;
      while (!m_valid && guard < 100) begin
         if (tog) cke = ~cke;
         c = cke;
         tick();
         if (c) lat++;
         guard++;
      end
      cke = 1'b1;
      chk({tag, " latency"}, 32'(lat), 32'd12);
   endtask

   task automatic handshake(input string tag);
      m_ready = 1'b1;
      tick();
      chk({tag, " valid_clr"}, 32'(m_valid), 32'd0);
      chk({tag, " ready_set"}, 32'(s_ready), 32'd1);
      m_ready = 1'b0;
   endtask

   initial begin
      int t, t_first, t_second, nacc, nval;
      bit acc;
      v1x = pk(123, 512, 300);
      v1y = pk(111, 91, 390);
      v3x = pk(0, 0, 0);
      v3y = pk(-2048, 2047, 0);

      // reset state
      reset = 1'b1; cke = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_x = '0; s_y = '0;
      tick(); tick(); tick();
      chk("rst s_ready", 32'(s_ready), 32'd0);
      chk("rst m_valid", 32'(m_valid), 32'd0);
      chk("rst outputs_zero", 32'((m_dx == '0) && (m_dy_stride == '0) && (m_offset == '0)), 32'd1);
      chk("rst ovf", 32'(m_overflow), 32'd0);
      reset = 1'b0;
      tick();
      chk("post_rst s_ready", 32'(s_ready), 32'd1);

      // 1: basic triangle
      run_tri("t1", v1x, v1y, 1'b0);
      check_out("t1", T1_DX, T1_DYS, T1_OFF, 1'b0);
      handshake("t1");

      // 2: backpressure holds OUT
      run_tri("t2", v1x, v1y, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("t2 hold_valid%0d", i), 32'(m_valid), 32'd1);
         chk($sformatf("t2 hold_ready%0d", i), 32'(s_ready), 32'd0);
         chk($sformatf("t2 hold_dx0_%0d", i), {12'd0, m_dx[0 +: RW]}, lo20(-20));
      end
      check_out("t2", T1_DX, T1_DYS, T1_OFF, 1'b0);
      handshake("t2");

      // 3: overflow case
      run_tri("t3", v3x, v3y, 1'b0);
      check_out("t3", T3_DX, T3_DYS, T3_OFF, 1'b1);
      handshake("t3");

      // 4: back-to-back with s_valid held high
      cke = 1'b1; m_ready = 1'b1; s_x = v1x; s_y = v1y; s_valid = 1'b1;
      t = 0; t_first = 0; t_second = 0; nacc = 0; nval = 0;
      for (int i = 0; i < 80; i++) begin
         acc = s_valid && s_ready;
         tick();
         t++;
         if (acc) begin
            if (nacc == 0) begin
               t_first = t; s_x = v3x; s_y = v3y;
            end else begin
               t_second = t; s_valid = 1'b0;
            end
            nacc++;
         end
         if (m_valid) begin
            if (nval == 0) check_out("t4a", T1_DX, T1_DYS, T1_OFF, 1'b0);
            else           check_out("t4b", T3_DX, T3_DYS, T3_OFF, 1'b1);
            nval++;
            if (nval == 2) break;
         end
      end
      chk("t4 nval", 32'(nval), 32'd2);
      chk("t4 accept_gap", 32'(t_second - t_first), 32'd14);
      tick();
      chk("t4 final_valid", 32'(m_valid), 32'd0);
      m_ready = 1'b0;

      // 5: reset in the middle of processing
      s_x = v1x; s_y = v1y; s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5 valid", 32'(m_valid), 32'd0);
      chk("t5 ready", 32'(s_ready), 32'd0);
      chk("t5 outputs_zero", 32'((m_dx == '0) && (m_dy_stride == '0) && (m_offset == '0)), 32'd1);
      chk("t5 ovf", 32'(m_overflow), 32'd0);
      m_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("t5 idle_valid%0d", i), 32'(m_valid), 32'd0);
      end
      m_ready = 1'b0;
      run_tri("t5b", v1x, v1y, 1'b0);
      check_out("t5b", T1_DX, T1_DYS, T1_OFF, 1'b0);
      handshake("t5b");

      // 6: clock enable toggling
      run_tri("t6", v1x, v1y, 1'b1);
      check_out("t6", T1_DX, T1_DYS, T1_OFF, 1'b0);
      m_ready = 1'b1; cke = 1'b0;
      tick();
      chk("t6 cke0_hold", 32'(m_valid), 32'd1);
      cke = 1'b1;
      handshake("t6");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
